// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, default widths
// and the arbiter state encoding.
package alu_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] OP_ADD      = 4'b0001;
    localparam logic [3:0] OP_SUB      = 4'b0010;
    localparam logic [3:0] OP_PASSATOC = 4'b0011;
    localparam logic [3:0] OP_PASSBTOC = 4'b0100;
    localparam logic [3:0] OP_INCAC    = 4'b0101;
    localparam logic [3:0] OP_DECAC    = 4'b0110;
    localparam logic [3:0] OP_LSHIFT1  = 4'b0111;
    localparam logic [3:0] OP_LSHIFT2  = 4'b1000;
    localparam logic [3:0] OP_LSHIFT9  = 4'b1001;
    localparam logic [3:0] OP_RSHIFT4  = 4'b1010;
    localparam logic [3:0] OP_RESET    = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter.
// ALU_ARB_LOCK_EN adds the req_lock ownership-hold signal.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
`ifdef ALU_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_zero;

`ifdef ALU_ARB_LOCK_EN
    modport master (
        output req, req_op, req_a, req_b, req_lock,
        input  gnt, rsp_valid, rsp_data, rsp_zero
    );
    modport slave (
        input  req, req_op, req_a, req_b, req_lock,
        output gnt, rsp_valid, rsp_data, rsp_zero
    );
`else
    modport master (
        output req, req_op, req_a, req_b,
        input  gnt, rsp_valid, rsp_data, rsp_zero
    );
    modport slave (
        input  req, req_op, req_a, req_b,
        output gnt, rsp_valid, rsp_data, rsp_zero
    );
`endif

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          any
);

    int            j;
    logic [PW-1:0] jj;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        jj   = '0;
        for (int i = 0; i < N; i++) begin
            j  = (int'(ptr) + i) % N;
            jj = PW'(j);
            if (!any && req[jj]) begin
                pick[jj] = 1'b1;
                idx      = jj;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one multi-cycle ALU between NUM_REQ requesters.
// ALU_ARB_LOCK_EN lets the owner keep the ALU across several operations.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int ALU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic              busy,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_z
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    arb_state_t         state, state_nxt;
    logic [PW-1:0]      ptr, owner, nxt_ptr;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] req_m, pick;
    logic [PW-1:0]      idx;
    logic               any, arb_ok, do_grant;

`ifdef ALU_ARB_LOCK_EN
    logic locked;

    // While the lock holds, only the owner may win; ptr already points past it.
    always_comb begin
        req_m = bus.req;
        if (locked && bus.req_lock[owner])
            req_m = bus.req & (NUM_REQ'(1) << owner);
    end
`else
    assign req_m = bus.req;
`endif

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req  (req_m),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx),
        .any  (any)
    );

    assign arb_ok   = (state == S_IDLE) || (state == S_RESP);
    assign do_grant = arb_ok && any;
    assign nxt_ptr  = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (any) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = any ? S_GRANT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            alu_start     <= 1'b0;
            alu_op        <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            locked        <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != S_IDLE);
            alu_start     <= 1'b0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            if (do_grant) begin
                bus.gnt <= pick;
                owner   <= idx;
                alu_op  <= bus.req_op[int'(idx)*OP_W +: OP_W];
                alu_a   <= bus.req_a[int'(idx)*DATA_W +: DATA_W];
                alu_b   <= bus.req_b[int'(idx)*DATA_W +: DATA_W];
`ifdef ALU_ARB_LOCK_EN
                locked  <= 1'b0;
`endif
            end
            if (state == S_GRANT) begin
                alu_start <= 1'b1;
                cnt       <= CW'(ALU_LAT - 1);
            end
            if (state == S_WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == S_WAIT && cnt == '0) begin
                bus.rsp_data         <= alu_c;
                bus.rsp_zero         <= alu_z;
                bus.rsp_valid[owner] <= 1'b1;
                ptr                  <= nxt_ptr;
`ifdef ALU_ARB_LOCK_EN
                locked               <= bus.req_lock[owner];
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 24-bit ALU.
// Lock scenario is built only when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NR  = 2;
    localparam int DW  = 24;
    localparam int OW  = 4;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          busy, alu_start, alu_z;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_c;

    int pass_cnt = 0;
    int total    = 0;
    int n_start  = 0;

    alu_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) bus ();

    alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .ALU_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_z     (alu_z)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_c = '0;
        case (alu_op)
            OP_ADD:      alu_c = alu_a + alu_b;
            OP_SUB:      alu_c = alu_a - alu_b;
            OP_PASSATOC: alu_c = alu_a;
            OP_PASSBTOC: alu_c = alu_b;
            OP_INCAC:    alu_c = alu_a + 24'd1;
            OP_DECAC:    alu_c = alu_a - 24'd1;
            OP_LSHIFT1:  alu_c = alu_a << 1;
            OP_LSHIFT2:  alu_c = alu_a << 2;
            OP_LSHIFT9:  alu_c = alu_a << 9;
            OP_RSHIFT4:  alu_c = alu_a >> 4;
            default:     alu_c = '0;
        endcase
        alu_z = (alu_op == OP_SUB) && (alu_c == '0);
    end

    always @(negedge clk) if (alu_start) n_start++;

    function automatic logic [127:0] outs();
        return {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_zero,
                busy, alu_start, alu_op, alu_a, alu_b};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_req(input int r, input logic [3:0] op,
                           input logic [23:0] a, input logic [23:0] b);
        bus.req_op[r*OW +: OW] = op;
        bus.req_a[r*DW +: DW]  = a;
        bus.req_b[r*DW +: DW]  = b;
        bus.req[r]             = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == '0 && n < 20);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One isolated transaction: grant, latency, result, flag, single start.
    task automatic run_one(input string nm, input int r, input logic [3:0] op,
                           input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] ed, input logic ez);
        int n, s0;
        s0 = n_start;
        set_req(r, op, a, b);
        wait_gnt(n);
        chk({nm, "_gnt"}, 128'(bus.gnt), 128'(2'b01 << r));
        bus.req[r] = 1'b0;
        wait_rsp(n);
        chk({nm, "_lat"}, 128'(n), 128'(LAT + 2));
        chk({nm, "_rspv"}, 128'(bus.rsp_valid), 128'(2'b01 << r));
        chk({nm, "_data"}, 128'(bus.rsp_data), 128'(ed));
        chk({nm, "_zero"}, 128'(bus.rsp_zero), 128'(ez));
        chk({nm, "_starts"}, 128'(n_start - s0), 128'(1));
    endtask

    typedef struct {
        int         r;
        logic [3:0] op;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] d;
        logic        z;
    } vec_t;

    vec_t tv[13];

    initial begin
        int n, gi, ri, cyc, cnt1, cntv, s0;
        logic [1:0]  g_ord[4];
        int          g_cyc[4];
        logic [1:0]  r_v[4];
        logic [23:0] r_d[4];
        logic        r_z[4];

        tv[0]  = '{0, OP_ADD,      24'd5,       24'd7,       24'd12,      1'b0};
        tv[1]  = '{1, OP_SUB,      24'd10,      24'd3,       24'd7,       1'b0};
        tv[2]  = '{0, OP_SUB,      24'd9,       24'd9,       24'd0,       1'b1};
        tv[3]  = '{1, OP_PASSATOC, 24'h123456,  24'h0,       24'h123456,  1'b0};
        tv[4]  = '{0, OP_PASSBTOC, 24'h0,       24'hABCDEF,  24'hABCDEF,  1'b0};
        tv[5]  = '{1, OP_INCAC,    24'hFFFFFF,  24'h0,       24'h000000,  1'b0};
        tv[6]  = '{0, OP_DECAC,    24'h000000,  24'h0,       24'hFFFFFF,  1'b0};
        tv[7]  = '{1, OP_LSHIFT1,  24'h400001,  24'h0,       24'h800002,  1'b0};
        tv[8]  = '{0, OP_LSHIFT2,  24'h000003,  24'h0,       24'h00000C,  1'b0};
        tv[9]  = '{1, OP_LSHIFT9,  24'h000001,  24'h0,       24'h000200,  1'b0};
        tv[10] = '{0, OP_RSHIFT4,  24'h0000F0,  24'h0,       24'h00000F,  1'b0};
        tv[11] = '{1, OP_RESET,    24'h000055,  24'h0,       24'h000000,  1'b0};
        tv[12] = '{0, OP_ADD,      24'hFFFFFF,  24'h1,       24'h000000,  1'b0};

        rst_n      = 1'b0;
        bus.req    = '0;
        bus.req_op = '0;
        bus.req_a  = '0;
        bus.req_b  = '0;
`ifdef ALU_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs(), 128'(0));

        for (int i = 0; i < 13; i++)
            run_one($sformatf("vec%0d", i), tv[i].r, tv[i].op,
                    tv[i].a, tv[i].b, tv[i].d, tv[i].z);
        @(negedge clk);
        chk("idle_after_vecs", 128'(busy), 128'(0));

        // Contention: both held, expect strict alternation with no bubble.
        do_reset();
        bus.req_op = {OP_SUB, OP_ADD};
        bus.req_a  = {24'd9, 24'd1};
        bus.req_b  = {24'd9, 24'd2};
        bus.req    = 2'b11;
        gi = 0; ri = 0; cyc = 0;
        while (ri < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt != '0 && gi < 4) begin
                g_ord[gi] = bus.gnt;
                g_cyc[gi] = cyc;
                gi++;
            end
            if (bus.rsp_valid != '0) begin
                r_v[ri] = bus.rsp_valid;
                r_d[ri] = bus.rsp_data;
                r_z[ri] = bus.rsp_zero;
                ri++;
            end
        end
        bus.req = '0;
        chk("cont_count", 128'(ri), 128'(4));
        chk("cont_order", 128'({g_ord[0], g_ord[1], g_ord[2], g_ord[3]}),
            128'(8'b01_10_01_10));
        chk("cont_spacing", 128'(g_cyc[1] - g_cyc[0]), 128'(LAT + 3));
        chk("cont_r0_data", 128'({r_v[0], r_d[0], r_z[0]}),
            128'({2'b01, 24'd3, 1'b0}));
        chk("cont_r1_data", 128'({r_v[1], r_d[1], r_z[1]}),
            128'({2'b10, 24'd0, 1'b1}));
        repeat (10) @(negedge clk);

        // Back-to-back: requester 1 re-requests in its rsp_valid cycle.
        set_req(1, OP_ADD, 24'd2, 24'd3);
        wait_gnt(n);
        bus.req[1] = 1'b0;
        wait_rsp(n);
        chk("b2b_first", 128'({bus.rsp_valid, bus.rsp_data}),
            128'({2'b10, 24'd5}));
        set_req(1, OP_ADD, 24'd4, 24'd4);
        wait_gnt(n);
        chk("b2b_gnt_delay", 128'(n), 128'(1));
        chk("b2b_gnt", 128'(bus.gnt), 128'(2'b10));
        bus.req[1] = 1'b0;
        wait_rsp(n);
        chk("b2b_second", 128'({bus.rsp_valid, bus.rsp_data, n}),
            128'({2'b10, 24'd8, LAT + 2}));
        repeat (3) @(negedge clk);

        // Reset while the ALU is busy aborts the transaction.
        set_req(0, OP_ADD, 24'd1, 24'd1);
        wait_gnt(n);
        bus.req[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs(), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cntv = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) cntv++;
        end
        chk("abort_no_rsp", 128'(cntv), 128'(0));
        run_one("post_abort", 0, OP_ADD, 24'd20, 24'd22, 24'd42, 1'b0);

        // A request raised and dropped while busy must leave no trace.
        set_req(0, OP_SUB, 24'd5, 24'd5);
        wait_gnt(n);
        bus.req[0] = 1'b0;
        s0 = n_start;
        repeat (2) @(negedge clk);
        set_req(1, OP_ADD, 24'd7, 24'd7);
        repeat (2) @(negedge clk);
        bus.req[1] = 1'b0;
        cnt1 = 0; cntv = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.gnt[1]) cnt1++;
            if (bus.rsp_valid != '0) cntv++;
        end
        chk("wd_no_gnt1", 128'(cnt1), 128'(0));
        chk("wd_starts", 128'(n_start - s0), 128'(1));
        chk("wd_one_rsp", 128'(cntv), 128'(1));
        chk("wd_last", 128'({bus.rsp_data, bus.rsp_zero, busy}),
            128'({24'd0, 1'b1, 1'b0}));

`ifdef ALU_ARB_LOCK_EN
        // Lock: requester 0 keeps the ALU three times, then yields.
        do_reset();
        bus.req_op   = {OP_ADD, OP_ADD};
        bus.req_a    = {24'd1, 24'd1};
        bus.req_b    = {24'd1, 24'd1};
        bus.req_lock = 2'b01;
        bus.req      = 2'b11;
        gi = 0; cyc = 0;
        while (gi < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt != '0) begin
                g_ord[gi] = bus.gnt;
                gi++;
                if (gi == 3) bus.req_lock = 2'b00;
            end
        end
        bus.req = '0;
        chk("lock_count", 128'(gi), 128'(4));
        chk("lock_order", 128'({g_ord[0], g_ord[1], g_ord[2], g_ord[3]}),
            128'(8'b01_01_01_10));
        repeat (12) @(negedge clk);
        chk("lock_idle", 128'(busy), 128'(0));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d",
                 pass_cnt, total);
        $fatal(1);
    end

endmodule
